// File: rtl/alu_multiciclo.sv
// alu_multiciclo: valid/ready ALU with registered results and flags.
// Define ALU_MULDIV_EN to build the iterative MUL/DIVU/REMU datapath.
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_resultado,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             div_zero,
  output logic             illegal_op
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_BUSY, S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_DONE
  } state_t;
`endif

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             cy_q;
  logic             ov_q;
  logic             dz_q;
  logic             ill_q;

  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] bx_d;
  logic [WIDTH-1:0] res_d;
  logic             cy_d;
  logic             ov_d;
  logic             ill_d;

  // Operands are used from the latch, so the ALU sits one cycle after accept
  always_comb begin
    bx_d  = (op_q == OP_SUB) ? ~b_q : b_q;
    sum_d = {1'b0, a_q} + {1'b0, bx_d}
          + {{WIDTH{1'b0}}, op_q == OP_SUB};
    res_d = '0;
    cy_d  = 1'b0;
    ov_d  = 1'b0;
    ill_d = 1'b0;
    unique case (op_q)
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_ADD, OP_SUB: begin
        res_d = sum_d[WIDTH-1:0];
        cy_d  = sum_d[WIDTH];
        ov_d  = (a_q[WIDTH-1] == bx_d[WIDTH-1])
             && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}},
                        $signed(a_q) < $signed(b_q)};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_NOR:  res_d = ~(a_q | b_q);
      default: ill_d = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] x_d;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH:0]   sh_d;
  logic [WIDTH-1:0] md_res_d;
  logic [WIDTH-1:0] dz_res_d;
  logic             is_md;
  logic             is_div;

  assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign is_md  = is_div || (op_q == OP_MUL);

  // p: product / partial remainder, x: multiplier / quotient, y: b
  always_comb begin
    p_d  = p_q;
    x_d  = x_q;
    y_d  = y_q;
    sh_d = {p_q, x_q[WIDTH-1]};
    if (op_q == OP_MUL) begin
      if (x_q[0]) p_d = p_q + y_q;
      x_d = x_q >> 1;
      y_d = y_q << 1;
    end else if (sh_d < {1'b0, y_q}) begin
      p_d = sh_d[WIDTH-1:0];
      x_d = {x_q[WIDTH-2:0], 1'b0};
    end else begin
      p_d = WIDTH'(sh_d - {1'b0, y_q});
      x_d = {x_q[WIDTH-2:0], 1'b1};
    end
    md_res_d = (op_q == OP_DIVU) ? x_d : p_d;
    dz_res_d = (op_q == OP_DIVU) ? '1 : a_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      zero_q      <= 1'b1;
      cy_q        <= 1'b0;
      ov_q        <= 1'b0;
      dz_q        <= 1'b0;
      ill_q       <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt_q       <= '0;
      p_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            op_q       <= alu_control;
            in_ready_q <= 1'b0;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q       <= res_d;
          zero_q      <= (res_d == '0);
          cy_q        <= cy_d;
          ov_q        <= ov_d;
          dz_q        <= 1'b0;
          ill_q       <= ill_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
`ifdef ALU_MULDIV_EN
          if (is_md) begin
            ill_q <= 1'b0;
            if (is_div && (b_q == '0)) begin
              res_q  <= dz_res_d;
              zero_q <= (dz_res_d == '0);
              dz_q   <= 1'b1;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= S_BUSY;
              cnt_q       <= '0;
              p_q         <= '0;
              x_q         <= a_q;
              y_q         <= b_q;
            end
          end
`endif
        end
`ifdef ALU_MULDIV_EN
        S_BUSY: begin
          p_q   <= p_d;
          x_q   <= x_d;
          y_q   <= y_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            res_q       <= md_res_d;
            zero_q      <= (md_res_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_resultado = res_q;
  assign zero          = zero_q;
  assign carry_out     = cy_q;
  assign overflow      = ov_q;
  assign div_zero      = dz_q;
  assign illegal_op    = ill_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// tb_alu_multiciclo: table vectors, handshake corner cases and a
// randomized run against a plain-arithmetic reference model.
module tb_alu_multiciclo;

  localparam int W = 32;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cy;
    logic         ov;
    logic         dz;
    logic         ill;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_resultado;
  logic         zero;
  logic         carry_out;
  logic         overflow;
  logic         div_zero;
  logic         illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  alu_multiciclo #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_resultado(out_resultado), .zero(zero),
    .carry_out(carry_out), .overflow(overflow),
    .div_zero(div_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] va,
                              input logic [W-1:0] vb, input logic [W-1:0] r,
                              input logic cy, input logic ov,
                              input logic dz, input logic ill, input int lat);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.res = r;
    v.cy = cy; v.ov = ov; v.dz = dz; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Reference model: plain integer arithmetic on the operand values
  function automatic vec_t model(input logic [3:0] op,
                                 input logic [W-1:0] va,
                                 input logic [W-1:0] vb);
    vec_t v;
    longint sa, sb, s;
    logic [63:0] ua, ub, p;
    v = mk(op, va, vb, '0, 0, 0, 0, 0, 1);
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    ua = {32'b0, va};
    ub = {32'b0, vb};
    case (op)
      4'b0000: v.res = va & vb;
      4'b0001: v.res = va | vb;
      4'b0010: begin
        p = ua + ub; v.res = p[31:0];
        v.cy = (p > 64'hFFFF_FFFF);
        s = sa + sb;
        v.ov = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
      end
      4'b0110: begin
        p = ua - ub; v.res = p[31:0];
        v.cy = (ua >= ub);
        s = sa - sb;
        v.ov = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
      end
      4'b0111: v.res = {31'b0, sa < sb};
      4'b0101: v.res = {31'b0, ua < ub};
      4'b1100: v.res = ~(va | vb);
`ifdef ALU_MULDIV_EN
      4'b1000: begin
        p = ua * ub; v.res = p[31:0]; v.lat = W + 1;
      end
      4'b1001: begin
        if (vb == 0) begin v.res = '1; v.dz = 1; end
        else begin p = ua / ub; v.res = p[31:0]; v.lat = W + 1; end
      end
      4'b1010: begin
        if (vb == 0) begin v.res = va; v.dz = 1; end
        else begin p = ua % ub; v.res = p[31:0]; v.lat = W + 1; end
      end
`endif
      default: v.ill = 1;
    endcase
    return v;
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    int k;
    @(negedge clk);
    in_valid = 1'b1; a = v.a; b = v.b; alu_control = v.op;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      chk({tag, " timeout"}, 64'(k), 64'(v.lat));
    end else begin
      chk({tag, " lat"}, 64'(k), 64'(v.lat));
      chk({tag, " res"}, 64'(out_resultado), 64'(v.res));
      chk({tag, " flags cy/ov/dz/ill/zero"},
          {59'b0, carry_out, overflow, div_zero, illegal_op, zero},
          {59'b0, v.cy, v.ov, v.dz, v.ill, v.res == 0});
      chk({tag, " in_ready in DONE"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " ready after"}, {62'b0, in_ready, out_valid}, 64'b10);
  endtask

  vec_t tbl[$];
  logic [3:0] ops[11];

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ovs;
    int md_wait;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alu_control = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset ready/valid", {62'b0, in_ready, out_valid}, 64'b10);
    chk("reset result", 64'(out_resultado), 64'd0);
    chk("reset zero/flags",
        {59'b0, zero, carry_out, overflow, div_zero, illegal_op},
        64'b10000);

    tbl.push_back(mk(4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000,
                     0, 1, 0, 0, 1));
    tbl.push_back(mk(4'b0110, 32'd5, 32'd5, 32'd0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000,
                     0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0,
                     0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b1011, 32'd9, 32'd3, 32'd0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF,
                     1, 1, 0, 0, 1));
    tbl.push_back(mk(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 0, 0, 1));
`ifdef ALU_MULDIV_EN
    tbl.push_back(mk(4'b1000, 32'd12345, 32'd6789, 32'd83810205,
                     0, 0, 0, 0, W + 1));
    tbl.push_back(mk(4'b1001, 32'd100, 32'd7, 32'd14, 0, 0, 0, 0, W + 1));
    tbl.push_back(mk(4'b1010, 32'd100, 32'd7, 32'd2, 0, 0, 0, 0, W + 1));
    tbl.push_back(mk(4'b1001, 32'd100, 32'd0, 32'hFFFF_FFFF,
                     0, 0, 1, 0, 1));
    tbl.push_back(mk(4'b1010, 32'd37, 32'd0, 32'd37, 0, 0, 1, 0, 1));
    tbl.push_back(mk(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
                     0, 0, 0, 0, W + 1));
    tbl.push_back(mk(4'b1001, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                     0, 0, 0, 0, W + 1));
`else
    tbl.push_back(mk(4'b1000, 32'd12345, 32'd6789, 32'd0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'b1001, 32'd100, 32'd0, 32'd0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'b1010, 32'd100, 32'd7, 32'd0, 0, 0, 0, 1, 1));
`endif
    foreach (tbl[i]) do_op(tbl[i], $sformatf("vec%0d", i));

    // DONE held with out_ready low; in_valid must be ignored
    @(negedge clk);
    in_valid = 1'b1; a = 32'd3; b = 32'd4; alu_control = 4'b0010;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; alu_control = 4'b0110;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d res", i), 64'(out_resultado), 64'd7);
      chk($sformatf("hold%0d valid/ready", i),
          {62'b0, out_valid, in_ready}, 64'b10);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold release", {62'b0, in_ready, out_valid}, 64'b10);

    // Back-to-back issue: one result every 3 cycles
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    a = 32'd10; b = 32'd20; alu_control = 4'b0010;
    ovs = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        ovs++;
        chk($sformatf("b2b res %0d", ovs), 64'(out_resultado), 64'd30);
      end
    end
    chk("b2b count", 64'(ovs), 64'd3);
    chk("b2b end valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Reset in the middle of an operation
`ifdef ALU_MULDIV_EN
    md_wait = 5;
`else
    md_wait = 0;
`endif
    @(negedge clk);
    in_valid = 1'b1; a = 32'd12345; b = 32'd6789; alu_control = 4'b1000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (md_wait) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst ready/valid", {62'b0, in_ready, out_valid}, 64'b10);
    chk("midrst result/zero", {31'b0, zero, out_resultado},
        {31'b0, 1'b1, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    ovs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) ovs++;
    end
    chk("midrst no result", 64'(ovs), 64'd0);
    do_op(mk(4'b1011, 32'd1, 32'd2, 32'd0, 0, 0, 0, 1, 1), "illegal1011");

    // Randomized run against the reference model
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
            4'b1100, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic [W-1:0] ra, rb;
      if ($urandom_range(0, 9) == 0) op = 4'($urandom);
      else op = ops[$urandom_range(0, 10)];
      ra = pick();
      rb = pick();
      do_op(model(op, ra, rb), $sformatf("rnd%0d op%b", i, op));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised, handshaked ALU generalising the team's 32-bit single-cycle ALU: same control encoding for logic, add, sub, set-less-than and NOR, plus iterative multiply and unsigned divide/remainder. Operands are accepted through a valid/ready handshake and results are returned the same way, so the block can sit between the register-read stage and write-back of the multicycle datapath. All results and flags come out of registers.

## Interface
- `WIDTH`, 32, operand/result width in bits; must be at least 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operands and opcode are valid.
- `in_ready`  out  1  block can accept a new operation.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `alu_control`  in  4  opcode.
- `out_valid`  out  1  result and flags are valid.
- `out_ready`  in  1  consumer takes the result.
- `out_resultado`  out  WIDTH  result.
- `zero`  out  1  `out_resultado == 0`.
- `carry_out`  out  1  carry (ADD) or no-borrow (SUB).
- `overflow`  out  1  signed overflow (ADD/SUB).
- `div_zero`  out  1  divide or remainder by zero.
- `illegal_op`  out  1  opcode not supported.

## Operation
- Opcodes:
  - `0000` AND
  - `0001` OR
  - `0010` ADD
  - `0110` SUB (a−b)
  - `0111` SLT (signed; result 1 or 0)
  - `0101` SLTU (unsigned)
  - `1100` NOR
  - `1000` MUL (low WIDTH bits of the unsigned product, which equals the signed low half)
  - `1001` DIVU (quotient)
  - `1010` REMU (remainder)
- All other opcodes: result 0 and `illegal_op`=1.
- FSM states:
  - IDLE: `in_ready`=1. An accept is `in_valid && in_ready`. At accept, the block latches `a`, `b` and `alu_control`.
  - An accepted single-cycle op goes to DONE with its result registered.
  - An accepted MUL/DIVU/REMU goes to BUSY.
  - BUSY: one shift-add (MUL) or restoring-divide (DIVU/REMU) step per cycle. An iteration counter of width clog2(WIDTH)+1 counts WIDTH steps, then the FSM goes to DONE.
  - DONE: `out_valid`=1. Outputs are held stable until `out_valid && out_ready`, then the FSM returns to IDLE.
- ADD/SUB:
  - The computation is WIDTH+1 bits wide.
  - `carry_out` = bit WIDTH.
  - SUB computes a + ~b + 1, so `carry_out`=1 means no borrow.
  - `overflow` = operand signs agree (with b inverted for SUB) and the result sign differs.
  - For every other opcode, `carry_out` and `overflow` are 0.
- Divide by zero (b=0): no iteration. DONE is reached one cycle after accept with quotient all-ones, remainder = a, and `div_zero`=1.
- `zero` is computed from the registered result for every opcode, including illegal ones.
- `in_ready` is 0 in BUSY and DONE. There is no overlap between operations.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State goes to IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `out_resultado`=0, `zero`=1, and all other flags 0.
  - The iteration counter is cleared.
  - Reset mid-BUSY or mid-DONE aborts the operation; no result is delivered.
- Single-cycle ops: accept at edge N, `out_valid`=1 after edge N+1.
- MUL/DIVU/REMU with b≠0: `out_valid`=1 after edge N+WIDTH+1.
- Back-to-back operations:
  - If `out_ready` is already high when DONE is entered, DONE lasts one cycle.
  - `in_ready` rises the cycle after the DONE handshake, so the minimum issue interval is 3 cycles for single-cycle ops.
- Inputs are ignored outside IDLE, and `in_valid` may drop without penalty. `a`/`b` changing during BUSY has no effect.

## Configuration
- `ALU_MULDIV_EN` defined:
  - MUL, DIVU and REMU are implemented as described above.
- Not defined:
  - The BUSY datapath (multiplier/divider registers) is not compiled.
  - Opcodes `1000`/`1001`/`1010` behave as illegal: 1-cycle latency, result 0, `illegal_op`=1, `div_zero`=0.
- The FSM has no BUSY state.

## Test plan
- Reset held for 2 cycles, then released → `in_ready`=1, `out_valid`=0, `out_resultado`=0, `zero`=1.
- WIDTH=32, ADD a=0x7FFFFFFF b=1 → result 0x80000000 after 1 cycle, `overflow`=1, `carry_out`=0. SUB a=5 b=5 → 0, `zero`=1, `carry_out`=1.
- SLT a=0xFFFFFFFF b=1 → 1. SLTU with the same operands → 0. NOR a=0 b=0 → 0xFFFFFFFF.
- With the macro on, MUL a=12345 b=6789 → 83810205 exactly WIDTH+1 cycles after accept. DIVU a=100 b=7 → 14. REMU → 2. DIVU b=0 → 0xFFFFFFFF with `div_zero`=1 after 1 cycle.
- Hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0, new `in_valid` ignored. Assert `out_ready` → IDLE the next cycle.
- Assert `rst_n`=0 mid-MUL → IDLE next cycle and no `out_valid`. Then opcode `1011` → `illegal_op`=1, result 0. With the macro off, opcode `1000` → `illegal_op`=1 after 1 cycle.
